// File: rtl/dmem_noc_arbiter_2to1.sv
// 2-to-1 arbiter sharing the dmem NoC master port between core LSU (m0) and debug/DMA (m1).
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: ties always go to m0 instead of round-robin.
package urv_typedef;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        resp_last;
  } mem_resp_t;
endpackage

module dmem_noc_arbiter_2to1
  import urv_typedef::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      m0_req_valid,
  output logic      m0_req_ready,
  input  mem_req_t  m0_req,
  output logic      m0_resp_valid,
  input  logic      m0_resp_ready,
  output mem_resp_t m0_resp,
  input  logic      m1_req_valid,
  output logic      m1_req_ready,
  input  mem_req_t  m1_req,
  output logic      m1_resp_valid,
  input  logic      m1_resp_ready,
  output mem_resp_t m1_resp,
  output logic      sn_req_valid,
  input  logic      sn_req_ready,
  output mem_req_t  sn_req,
  input  logic      sn_resp_valid,
  output logic      sn_resp_ready,
  input  mem_resp_t sn_resp
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             owner;
  logic             rr_last;
  logic             hold;
  logic             hold_id;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             tie_pick;
  logic             can_req;
  logic             req_hs;
  logic             resp_done;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign tie_pick = 1'b0;
`else
  assign tie_pick = ~rr_last;
`endif

  assign can_req = cnt < CNT_W'(MAX_OUTSTANDING);

  // Lock to the owner while anything is outstanding, then to a stalled request.
  always_comb begin
    grant = tie_pick;
    if (cnt != '0)
      grant = owner;
    else if (hold)
      grant = hold_id;
    else if (m0_req_valid && !m1_req_valid)
      grant = 1'b0;
    else if (m1_req_valid && !m0_req_valid)
      grant = 1'b1;
  end

  assign sn_req        = grant ? m1_req : m0_req;
  assign sn_req_valid  = !rst && can_req && (grant ? m1_req_valid : m0_req_valid);
  assign m0_req_ready  = !rst && !grant && can_req && sn_req_ready;
  assign m1_req_ready  = !rst && grant && can_req && sn_req_ready;

  assign sn_resp_ready = !rst && (owner ? m1_resp_ready : m0_resp_ready);
  assign m0_resp_valid = !rst && !owner && sn_resp_valid;
  assign m1_resp_valid = !rst && owner && sn_resp_valid;
  assign m0_resp       = sn_resp;
  assign m1_resp       = sn_resp;

  assign req_hs    = sn_req_valid && sn_req_ready;
  assign resp_done = sn_resp_valid && sn_resp_ready && sn_resp.resp_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= 1'b0;
      rr_last <= 1'b1;
      hold    <= 1'b0;
      hold_id <= 1'b0;
      cnt     <= '0;
    end else begin
      if (req_hs) begin
        owner   <= grant;
        rr_last <= grant;
        hold    <= 1'b0;
      end else if (sn_req_valid) begin
        hold    <= 1'b1;
        hold_id <= grant;
      end
      // A done with nothing outstanding is a protocol error; cnt saturates at 0.
      if (req_hs && !resp_done)
        cnt <= cnt + CNT_W'(1);
      else if (!req_hs && resp_done && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_dmem_noc_arbiter_2to1.sv
// Self-checking bench for dmem_noc_arbiter_2to1: directed scenarios plus a randomized run
// against a transaction-level model of ownership, outstanding count and stalled requests.
module tb_dmem_noc_arbiter_2to1;
  import urv_typedef::*;

  localparam int MAX = 2;

  logic      clk = 1'b0;
  logic      rst;
  logic      m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
  logic      m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
  logic      sn_req_valid, sn_req_ready, sn_resp_valid, sn_resp_ready;
  mem_req_t  m0_req, m1_req, sn_req;
  mem_resp_t m0_resp, m1_resp, sn_resp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_noc_arbiter_2to1 #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req(m0_req),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp(m0_resp),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req(m1_req),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp(m1_resp),
    .sn_req_valid(sn_req_valid), .sn_req_ready(sn_req_ready), .sn_req(sn_req),
    .sn_resp_valid(sn_resp_valid), .sn_resp_ready(sn_resp_ready), .sn_resp(sn_resp)
  );

  function automatic mem_req_t rand_req();
    mem_req_t r;
    r.addr  = $urandom();
    r.wdata = $urandom();
    r.be    = 4'($urandom());
    r.we    = 1'($urandom());
    return r;
  endfunction

  function automatic mem_resp_t rand_resp(input logic last);
    mem_resp_t r;
    r.rdata     = $urandom();
    r.err       = 1'($urandom());
    r.resp_last = last;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    m0_req_valid = 0; m1_req_valid = 0; sn_req_ready = 0; sn_resp_valid = 0;
    m0_resp_ready = 0; m1_resp_ready = 0;
    m0_req = rand_req(); m1_req = rand_req(); sn_resp = rand_resp(1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    m0_req_valid = 1; m1_req_valid = 1; sn_req_ready = 1; sn_resp_valid = 1;
    m0_resp_ready = 1; m1_resp_ready = 1;
    tick(); settle();
    n_cmp++; if ({sn_req_valid, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, sn_resp_ready} !== 6'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 000000",
        {sn_req_valid, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, sn_resp_ready});
    end
    rst = 0; idle();
    m0_req_valid = 1; sn_req_ready = 1; settle();
    n_cmp++; if (sn_req_valid !== 1'b1 || sn_req !== m0_req) begin
      n_err++; $display("FAIL reset_first_req: valid=%b req=%h expected valid=1 req=%h", sn_req_valid, sn_req, m0_req);
    end
    tick(); idle();
  endtask

  // Plan item 1: first tie to m0, m1 waits for m0's response, ties alternate.
  task automatic test_tie_rr();
    mem_req_t exp_req;
    do_reset();
    m0_req_valid = 1; m1_req_valid = 1; sn_req_ready = 1; settle();
    n_cmp++; if (sn_req_valid !== 1'b1 || sn_req !== m0_req || m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin
      n_err++; $display("FAIL tie_first: v=%b req=%h r0=%b r1=%b expected v=1 req=%h r0=1 r1=0",
        sn_req_valid, sn_req, m0_req_ready, m1_req_ready, m0_req);
    end
    tick();
    m0_req_valid = 0; sn_resp_valid = 1; sn_resp = rand_resp(1'b1); m0_resp_ready = 1; settle();
    n_cmp++; if (m1_req_ready !== 1'b0 || sn_req_valid !== 1'b0 || m0_resp_valid !== 1'b1 || m1_resp_valid !== 1'b0) begin
      n_err++; $display("FAIL tie_m1_blocked: r1=%b snv=%b rv0=%b rv1=%b expected 0 0 1 0",
        m1_req_ready, sn_req_valid, m0_resp_valid, m1_resp_valid);
    end
    tick();
    sn_resp_valid = 0; m0_resp_ready = 0; settle();
    n_cmp++; if (sn_req_valid !== 1'b1 || sn_req !== m1_req || m1_req_ready !== 1'b1) begin
      n_err++; $display("FAIL tie_m1_grant: v=%b req=%h r1=%b expected v=1 req=%h r1=1", sn_req_valid, sn_req, m1_req_ready, m1_req);
    end
    tick();
    m1_req_valid = 0; sn_resp_valid = 1; sn_resp = rand_resp(1'b1); m1_resp_ready = 1; settle();
    n_cmp++; if (m1_resp_valid !== 1'b1 || m0_resp_valid !== 1'b0 || m1_resp !== sn_resp || sn_resp_ready !== 1'b1) begin
      n_err++; $display("FAIL tie_m1_resp: rv1=%b rv0=%b srr=%b expected 1 0 1", m1_resp_valid, m0_resp_valid, sn_resp_ready);
    end
    tick();
    sn_resp_valid = 0; m1_resp_ready = 0; m0_req_valid = 1; m1_req_valid = 1; settle();
    n_cmp++; if (sn_req !== m0_req || m0_req_ready !== 1'b1) begin
      n_err++; $display("FAIL tie_second: req=%h r0=%b expected req=%h r0=1", sn_req, m0_req_ready, m0_req);
    end
    tick();
    m0_req_valid = 0; m1_req_valid = 0; sn_resp_valid = 1; sn_resp = rand_resp(1'b1); m0_resp_ready = 1;
    tick();
    sn_resp_valid = 0; m0_resp_ready = 0; m0_req_valid = 1; m1_req_valid = 1; settle();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_req = m0_req;
`else
    exp_req = m1_req;
`endif
    n_cmp++; if (sn_req !== exp_req) begin
      n_err++; $display("FAIL tie_third: req=%h expected %h", sn_req, exp_req);
    end
    tick(); idle();
  endtask

  // Plan item 2: counter saturation at MAX, no same-cycle bypass.
  task automatic test_max_outstanding();
    do_reset();
    m0_req_valid = 1; m1_req_valid = 1; sn_req_ready = 1;
    for (int i = 0; i < MAX; i++) begin
      settle();
      n_cmp++; if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin
        n_err++; $display("FAIL max_issue%0d: r0=%b r1=%b expected 1 0", i, m0_req_ready, m1_req_ready);
      end
      tick(); m0_req = rand_req();
    end
    sn_resp_valid = 1; sn_resp = rand_resp(1'b1); m0_resp_ready = 1; settle();
    n_cmp++; if (m0_req_ready !== 1'b0 || m1_req_ready !== 1'b0 || sn_req_valid !== 1'b0) begin
      n_err++; $display("FAIL max_full: r0=%b r1=%b snv=%b expected 0 0 0", m0_req_ready, m1_req_ready, sn_req_valid);
    end
    tick();
    m0_req_valid = 0; settle();
    n_cmp++; if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0 || sn_req_valid !== 1'b0) begin
      n_err++; $display("FAIL max_resume: r0=%b r1=%b snv=%b expected 1 0 0", m0_req_ready, m1_req_ready, sn_req_valid);
    end
    tick();
    sn_resp_valid = 0; m0_resp_ready = 0; settle();
    n_cmp++; if (m1_req_ready !== 1'b1 || sn_req !== m1_req) begin
      n_err++; $display("FAIL max_m1_after: r1=%b req=%h expected 1 %h", m1_req_ready, sn_req, m1_req);
    end
    tick(); idle();
  endtask

  // Plan item 3: stalled m1 request keeps the grant despite m0 arriving.
  task automatic test_hold();
    do_reset();
    m1_req_valid = 1; sn_req_ready = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) m0_req_valid = 1;
      if (c == 4) sn_req_ready = 1;
      settle();
      n_cmp++; if (sn_req_valid !== 1'b1 || sn_req !== m1_req || m0_req_ready !== 1'b0 || m1_req_ready !== sn_req_ready) begin
        n_err++; $display("FAIL hold_c%0d: v=%b req=%h r0=%b r1=%b expected v=1 req=%h r0=0 r1=%b",
          c, sn_req_valid, sn_req, m0_req_ready, m1_req_ready, m1_req, sn_req_ready);
      end
      tick();
    end
    idle();
  endtask

  // Plan item 4: request and final response in the same cycle keep cnt and owner.
  task automatic test_same_cycle();
    do_reset();
    m0_req_valid = 1; sn_req_ready = 1;
    tick();
    m0_req = rand_req(); m1_req_valid = 1;
    sn_resp_valid = 1; sn_resp = rand_resp(1'b1); m0_resp_ready = 1; m1_resp_ready = 1; settle();
    n_cmp++; if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0 || m1_resp_valid !== 1'b0 || m0_resp_valid !== 1'b1) begin
      n_err++; $display("FAIL same_cycle: r0=%b r1=%b rv1=%b rv0=%b expected 1 0 0 1", m0_req_ready, m1_req_ready, m1_resp_valid, m0_resp_valid);
    end
    tick();
    m0_req_valid = 0; sn_resp = rand_resp(1'b0); settle();
    n_cmp++; if (m1_req_ready !== 1'b0 || m1_resp_valid !== 1'b0 || m0_resp_valid !== 1'b1) begin
      n_err++; $display("FAIL same_cycle_kept: r1=%b rv1=%b rv0=%b expected 0 0 1", m1_req_ready, m1_resp_valid, m0_resp_valid);
    end
    tick();
    sn_resp = rand_resp(1'b1);
    tick();
    sn_resp_valid = 0; settle();
    n_cmp++; if (m1_req_ready !== 1'b1) begin
      n_err++; $display("FAIL same_cycle_release: r1=%b expected 1", m1_req_ready);
    end
    tick(); idle();
  endtask

  // Plan item 5: three-beat response with toggling ready; only the last beat releases.
  task automatic test_multibeat();
    int beat;
    do_reset();
    m0_req_valid = 1; sn_req_ready = 1;
    tick();
    m0_req_valid = 0; m1_req_valid = 1; beat = 0;
    for (int c = 0; c < 6; c++) begin
      m0_resp_ready = 1'(c % 2); sn_resp_valid = 1; sn_resp = rand_resp(beat == 2); settle();
      n_cmp++; if (sn_resp_ready !== m0_resp_ready || m0_resp !== sn_resp || m0_resp_valid !== 1'b1 || m1_req_ready !== 1'b0) begin
        n_err++; $display("FAIL multibeat_c%0d: srr=%b rv0=%b r1=%b expected srr=%b rv0=1 r1=0",
          c, sn_resp_ready, m0_resp_valid, m1_req_ready, m0_resp_ready);
      end
      if (m0_resp_ready) beat++;
      tick();
    end
    sn_resp_valid = 0; m0_resp_ready = 0; settle();
    n_cmp++; if (m1_req_ready !== 1'b1) begin
      n_err++; $display("FAIL multibeat_release: r1=%b expected 1", m1_req_ready);
    end
    tick(); idle();
  endtask

  // Plan item 6: reset with two outstanding clears count, owner and round-robin.
  task automatic test_reset_mid();
    do_reset();
    m0_req_valid = 1; sn_req_ready = 1;
    tick(); tick();
    rst = 1; m1_req_valid = 1; sn_resp_valid = 1; m0_resp_ready = 1; m1_resp_ready = 1;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_cmp++; if ({sn_req_valid, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, sn_resp_ready} !== 6'b0) begin
        n_err++; $display("FAIL reset_mid_outputs%0d: got %b expected 000000", c,
          {sn_req_valid, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, sn_resp_ready});
      end
      tick();
    end
    rst = 0; m0_req_valid = 0; m1_resp_ready = 0; sn_resp = rand_resp(1'b0); settle();
    n_cmp++; if (m1_req_ready !== 1'b1 || m0_resp_valid !== 1'b1 || m1_resp_valid !== 1'b0 || sn_resp_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_cleared: r1=%b rv0=%b rv1=%b srr=%b expected 1 1 0 1",
        m1_req_ready, m0_resp_valid, m1_resp_valid, sn_resp_ready);
    end
    m1_req_valid = 1; m0_req_valid = 1; sn_resp_valid = 0; settle();
    n_cmp++; if (sn_req !== m0_req || m0_req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_tie: req=%h r0=%b expected %h 1", sn_req, m0_req_ready, m0_req);
    end
    tick(); idle();
  endtask

  // Randomized run against a transaction-level model.
  task automatic test_random();
    int own, out, pend, last_win, g;
    bit known, room, exp_v, hs, done, own_rdy;
    do_reset();
    own = 0; out = 0; pend = -1; last_win = 1;
    for (int c = 0; c < 3000; c++) begin
      m0_req_valid = 1'($urandom()); m1_req_valid = 1'($urandom());
      m0_req = rand_req(); m1_req = rand_req();
      sn_req_ready = ($urandom_range(0, 2) != 0);
      sn_resp_valid = ($urandom_range(0, 2) == 0); sn_resp = rand_resp(1'($urandom()));
      m0_resp_ready = 1'($urandom()); m1_resp_ready = 1'($urandom());
      known = 1; g = 0;
      if (out > 0) g = own;
      else if (pend >= 0) g = pend;
      else if (m0_req_valid && !m1_req_valid) g = 0;
      else if (m1_req_valid && !m0_req_valid) g = 1;
      else if (m0_req_valid && m1_req_valid) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        g = 0;
`else
        g = 1 - last_win;
`endif
      end else known = 0;
      room = (out < MAX);
      exp_v = known && room && (g == 1 ? m1_req_valid : m0_req_valid);
      own_rdy = (own == 1) ? m1_resp_ready : m0_resp_ready;
      settle();
      n_cmp++; if (sn_req_valid !== exp_v || (exp_v && sn_req !== (g == 1 ? m1_req : m0_req))) begin
        n_err++; $display("FAIL rand_req c%0d: v=%b req=%h expected v=%b grant=m%0d", c, sn_req_valid, sn_req, exp_v, g);
      end
      if (known) begin
        n_cmp++; if (m0_req_ready !== (g == 0 && room && sn_req_ready) || m1_req_ready !== (g == 1 && room && sn_req_ready)) begin
          n_err++; $display("FAIL rand_ready c%0d: r0=%b r1=%b expected grant=m%0d room=%b", c, m0_req_ready, m1_req_ready, g, room);
        end
      end
      n_cmp++; if (m0_resp_valid !== (own == 0 && sn_resp_valid) || m1_resp_valid !== (own == 1 && sn_resp_valid) ||
                   sn_resp_ready !== own_rdy || (own == 0 ? m0_resp : m1_resp) !== sn_resp) begin
        n_err++; $display("FAIL rand_resp c%0d: rv0=%b rv1=%b srr=%b expected owner=m%0d srr=%b", c,
          m0_resp_valid, m1_resp_valid, sn_resp_ready, own, own_rdy);
      end
      hs = exp_v && sn_req_ready;
      done = sn_resp_valid && own_rdy && sn_resp.resp_last;
      tick();
      if (hs) begin own = g; last_win = g; pend = -1; end
      else if (exp_v) pend = g;
      if (hs && !done) out++;
      else if (done && !hs && out > 0) out--;
    end
    idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_tie_rr();
    test_max_outstanding();
    test_hold();
    test_same_cycle();
    test_multibeat();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_noc_arbiter_2to1.md
Name: dmem_noc_arbiter_2to1

Overview:
Shares the single data-memory NoC master port (feeding the dmem 1-to-4 router) between two requesters: m0 (core LSU) and m1 (debug/DMA).
- Arbitrates round-robin and locks the grant to the owning master while its transactions are outstanding.
- Routes responses back to the owner.
- Uses mem_req_t/mem_resp_t from urv_typedef.

Parameters:
MAX_OUTSTANDING, 2, max requests in flight from current owner (>=1); counter width CNT_W = $clog2(MAX_OUTSTANDING+1)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
m0_req_valid  input  1  master 0 request valid
m0_req_ready  output  1  master 0 request ready
m0_req  input  mem_req_t  master 0 request payload
m0_resp_valid  output  1  master 0 response valid
m0_resp_ready  input  1  master 0 response ready
m0_resp  output  mem_resp_t  master 0 response payload
m1_req_valid / m1_req_ready / m1_req / m1_resp_valid / m1_resp_ready / m1_resp  same as m0, for master 1
sn_req_valid  output  1  downstream (router mn) request valid
sn_req_ready  input  1  downstream request ready
sn_req  output  mem_req_t  downstream request payload
sn_resp_valid  input  1  downstream response valid
sn_resp_ready  output  1  downstream response ready
sn_resp  input  mem_resp_t  downstream response payload (resp_last marks final beat)

Behaviour:
- One clock, clk; rst is synchronous and active-high. All state updates on the rising edge of clk.
- State:
  - owner (1b, reset 0)
  - cnt (CNT_W, reset 0)
  - rr_last (1b, reset 1, so m0 wins the first tie)
  - hold (1b, reset 0)
  - hold_id (1b, reset 0)
- While rst=1, all outputs are forced to 0: sn_req_valid, m*_req_ready, m*_resp_valid, sn_resp_ready.
- Grant selection (combinational; zero-cycle latency from m*_req_valid to sn_req_valid):
  - cnt>0: grant = owner; the other master is blocked (its req_ready=0).
  - cnt==0 and hold=1: grant = hold_id.
  - cnt==0 and hold=0, only one master valid: grant = that master.
  - cnt==0 and hold=0, both valid: grant = ~rr_last.
- sn_req = grant master's req; sn_req_valid = grant master's valid && (cnt < MAX_OUTSTANDING).
- grant master's req_ready = sn_req_ready && (cnt < MAX_OUTSTANDING); the non-grant master's req_ready=0.
- Stability: if sn_req_valid=1 and sn_req_ready=0, set hold=1, hold_id=grant. Clear hold on the sn request handshake. The grant never switches while a downstream request is pending.
- Request handshake (sn_req_valid && sn_req_ready): owner <= grant, rr_last <= grant, cnt increments.
- Response routing:
  - owner master's resp_valid = sn_resp_valid; its resp = sn_resp.
  - sn_resp_ready = owner master's resp_ready.
  - non-owner resp_valid=0; its resp payload = sn_resp (don't-care).
- Response-done event: sn_resp_valid && sn_resp_ready && sn_resp.resp_last. On this event cnt decrements.
- Counter boundaries:
  - Request handshake and response-done in the same cycle: cnt unchanged.
  - cnt==MAX_OUTSTANDING: requests blocked that cycle, even if a response-done occurs in the same cycle (no bypass). Acceptance resumes the next cycle.
  - cnt==0 and a response-done occurs: protocol error; cnt saturates at 0.
- Ownership: owner may change only when cnt==0.
  - With cnt==1 and the owner's next request handshaking in the same cycle as response-done, ownership is retained (cnt stays 1).
- Reset mid-transaction: cnt, hold, and owner are cleared. In-flight responses are discarded by system convention (downstream slaves are reset by the same rst).

Optional Feature:
DMEM_ARB_FIXED_PRIO_EN
- Defined: the tie case (cnt==0, hold=0, both valid) always grants m0. rr_last still updates but is ignored.
- Undefined: round-robin as above.
- Lock, hold, and counter behaviour are identical in both builds.

Test Plan:
1. Reset, then m0 and m1 both valid in cycle 1 with sn_req_ready=1 -> sn_req = m0_req in cycle 1; m1 is granted after m0's resp_last handshake brings cnt to 0; the next tie grants m0 again.
2. m0 issues 2 requests back-to-back, no responses (MAX_OUTSTANDING=2) -> cnt=2; third m0 request has m0_req_ready=0; m1 is blocked (m1_req_ready=0) until cnt returns to 0.
3. m1 valid with sn_req_ready=0 for 3 cycles, m0 raises valid in cycle 2 -> sn_req stays m1 (hold=1) until m1's handshake in cycle 4.
4. cnt=1 (owner m0); m0 request handshake and sn resp_last handshake in the same cycle -> cnt stays 1, owner stays m0, m1_resp_valid=0 throughout.
5. Multi-beat response (3 beats, resp_last on beat 3) with m0_resp_ready toggling -> sn_resp_ready mirrors m0_resp_ready; cnt decrements only after beat 3.
6. Assert rst with cnt=2 -> next cycle cnt=0, hold=0, owner=0; all valids/readies are 0 while rst=1. Build with DMEM_ARB_FIXED_PRIO_EN: repeated ties always grant m0.
